instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven instruction fetch over req/ack with flush, misalign and timeout handling
module instr_fetch #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] FAULT_INSTR    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic        pc_advance
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  logic [1:0] state;
  logic       drop;
  logic [7:0] timer;
  logic       expired;
  assign expired = timer == 8'(TIMEOUT_CYCLES - 1);
  // Fetch FSM: issue one request, capture or time out, hold the word until decode takes it or a flush kills it
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_fault <= 1'b0;
      pc_advance  <= 1'b0;
      drop        <= 1'b0;
      timer       <= '0;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        IDLE: begin
          if (!flush) begin
            if (pc_in[1:0] != 2'b00) begin
              state       <= HOLD;
              instr_out   <= FAULT_INSTR;
              instr_pc    <= pc_in;
              instr_fault <= 1'b1;
              instr_valid <= 1'b1;
            end else begin
              state     <= WAIT;
              imem_req  <= 1'b1;
              imem_addr <= pc_in;
              timer     <= '0;
            end
          end
        end
        WAIT: begin
          if (imem_ack || expired) begin
            imem_req <= 1'b0;
            drop     <= 1'b0;
            if (drop || flush) begin
              state <= IDLE;
            end else begin
              state       <= HOLD;
              instr_out   <= imem_ack ? imem_rdata : FAULT_INSTR;
              instr_pc    <= imem_addr;
              instr_fault <= !imem_ack;
              instr_valid <= 1'b1;
            end
          end else begin
            timer <= timer + 8'd1;
            drop  <= drop | flush;
          end
        end
        HOLD: begin
          if (flush || instr_ready) begin
            instr_valid <= 1'b0;
            pc_advance  <= !flush;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven scoreboard bench for instr_fetch
module tb_instr_fetch;
  localparam logic [31:0] FI = 32'h0000_0013;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_in = '0;
  logic        flush = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        pc_advance;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] rdata;
    int          dly;
    int          hold;
    int          nreq;
    logic [31:0] eout;
    logic [31:0] epc;
    logic        efault;
  } vec_t;
  typedef struct {
    logic [31:0] out;
    logic [31:0] pc;
    logic        fault;
  } exp_t;
  vec_t vecs[6];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  instr_fetch #(.TIMEOUT_CYCLES(4), .FAULT_INSTR(FI)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_fault(instr_fault), .pc_advance(pc_advance)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n = 0;
    int   c = 0;
    pc_in = v.pc;
    flush = 1'b0;
    instr_ready = 1'b0;
    sb.push_back('{v.eout, v.epc, v.efault});
    step;
    while (!instr_valid && c < 50) begin
      if (imem_req) begin
        chk("imem_addr", imem_addr, v.pc);
        if (n == v.dly) begin
          imem_ack = 1'b1;
          imem_rdata = v.rdata;
        end
        n++;
      end
      step;
      imem_ack = 1'b0;
      c++;
    end
    chk("instr_valid", instr_valid, 1);
    chk("req_cycles", n, v.nreq);
    e = sb.pop_front();
    chk("instr_out", instr_out, e.out);
    chk("instr_pc", instr_pc, e.pc);
    chk("instr_fault", instr_fault, e.fault);
    imem_ack = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    for (int i = 0; i < v.hold; i++) begin
      step;
      chk("hold_valid", instr_valid, 1);
      chk("hold_out", instr_out, e.out);
      chk("hold_adv", pc_advance, 0);
    end
    imem_ack = 1'b0;
    instr_ready = 1'b1;
    step;
    chk("adv_pulse", pc_advance, 1);
    chk("valid_drop", instr_valid, 0);
    instr_ready = 1'b0;
    flush = 1'b1;
    step;
    chk("adv_once", pc_advance, 0);
    chk("idle_req", imem_req, 0);
  endtask
  initial begin
    vecs[0] = '{32'h100, 32'h8C22_0004, 3, 0, 4, 32'h8C22_0004, 32'h100, 1'b0};
    vecs[1] = '{32'h104, 32'h1111_1111, 0, 5, 1, 32'h1111_1111, 32'h104, 1'b0};
    vecs[2] = '{32'h102, 32'hFFFF_FFFF, 0, 2, 0, FI,            32'h102, 1'b1};
    vecs[3] = '{32'h300, 32'h2222_2222, 99, 3, 4, FI,           32'h300, 1'b1};
    vecs[4] = '{32'h10C, 32'hABCD_1234, 1, 1, 2, 32'hABCD_1234, 32'h10C, 1'b0};
    vecs[5] = '{32'h001, 32'h3333_3333, 0, 0, 0, FI,            32'h001, 1'b1};
    step;
    step;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_out", instr_out, 0);
    rst = 1'b0;
    pc_in = 32'h400;
    flush = 1'b0;
    step;
    chk("a_req", imem_req, 1);
    step;
    rst = 1'b1;
    flush = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step;
    step;
    chk("a_req", imem_req, 0);
    chk("a_addr", imem_addr, 0);
    chk("a_valid", instr_valid, 0);
    chk("a_out", instr_out, 0);
    chk("a_pc", instr_pc, 0);
    chk("a_fault", instr_fault, 0);
    chk("a_adv", pc_advance, 0);
    rst = 1'b0;
    step;
    imem_ack = 1'b0;
    chk("a_late_req", imem_req, 0);
    chk("a_late_valid", instr_valid, 0);
    chk("a_late_out", instr_out, 0);
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    pc_in = 32'h500;
    flush = 1'b0;
    step;
    chk("b_req", imem_req, 1);
    chk("b_addr", imem_addr, 32'h500);
    flush = 1'b1;
    step;
    flush = 1'b0;
    step;
    chk("b_req_kept", imem_req, 1);
    imem_ack = 1'b1;
    imem_rdata = 32'h7777_7777;
    pc_in = 32'h200;
    step;
    imem_ack = 1'b0;
    chk("b_valid", instr_valid, 0);
    chk("b_req_off", imem_req, 0);
    step;
    chk("b_new_req", imem_req, 1);
    chk("b_new_addr", imem_addr, 32'h200);
    chk("b_adv", pc_advance, 0);
    imem_ack = 1'b1;
    imem_rdata = 32'h1234_5678;
    step;
    imem_ack = 1'b0;
    chk("b_valid2", instr_valid, 1);
    chk("b_out2", instr_out, 32'h1234_5678);
    chk("b_pc2", instr_pc, 32'h200);
    flush = 1'b1;
    instr_ready = 1'b1;
    step;
    instr_ready = 1'b0;
    chk("b_hold_flush_valid", instr_valid, 0);
    chk("b_hold_flush_adv", pc_advance, 0);
    step;
    chk("b_idle_req", imem_req, 0);
    pc_in = 32'h600;
    flush = 1'b0;
    step;
    chk("c_req", imem_req, 1);
    flush = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'h9999_9999;
    step;
    imem_ack = 1'b0;
    chk("c_valid", instr_valid, 0);
    chk("c_req_off", imem_req, 0);
    step;
    chk("c_valid2", instr_valid, 0);
    chk("c_adv", pc_advance, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
